// File: rtl/aes_round_ctrl.sv
// AES round controller: sequences NR rounds of an external round-function
// datapath over a 128-bit state register with a valid/ready handshake on
// both ends and a synchronous abort.
module aes_round_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    input  logic         abort,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic [127:0] rf_in,
    output logic         rf_final,
    input  logic [127:0] rf_out,
    output logic         busy
);

    localparam logic [3:0] LAST = 4'(NR);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t       state, nxt;
    logic [3:0]   rnd;
    logic [127:0] st;
    logic         live;
    logic         accept;
    logic         last_rnd;

    assign last_rnd  = (rnd == LAST);
    assign in_ready  = (state == IDLE) && live;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign data_out  = st;
    assign rf_in     = st;
    assign rf_final  = (state == ROUND) && last_rnd;
    assign rk_idx    = (state == ROUND) ? rnd : 4'd0;

    // live goes high on the first edge after reset release, so in_ready
    // stays low for the whole reset interval and rises one cycle later
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) live <= 1'b0;
        else      live <= 1'b1;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    // Next-state logic; abort outranks every other exit from ROUND/DONE
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (accept) nxt = ROUND;
            ROUND: begin
                if (abort)         nxt = IDLE;
                else if (last_rnd) nxt = DONE;
            end
            DONE:    if (abort || out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // State register and round counter: initial AddRoundKey on accept,
    // then one datapath pass per cycle; counter parks at NR on the last round
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st  <= '0;
            rnd <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        st  <= data_in ^ rk;
                        rnd <= 4'd1;
                    end
                end
                ROUND: begin
                    if (abort) begin
                        st  <= '0;
                        rnd <= '0;
                    end else begin
                        st <= rf_out;
                        if (!last_rnd) rnd <= rnd + 4'd1;
                    end
                end
                DONE: begin
                    if (abort) begin
                        st  <= '0;
                        rnd <= '0;
                    end else if (out_ready) begin
                        rnd <= '0;
                    end
                end
                default: begin
                    st  <= '0;
                    rnd <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: supplies an AES-128 key store and round-function
// datapath, drives directed vectors and compares against FIPS-197 results.
module tb_aes_round_ctrl;

    localparam int NR = 10;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk, rst;
    logic         in_valid, in_ready, out_valid, out_ready, abort;
    logic         rf_final, busy;
    logic [127:0] data_in, data_out, rk, rf_in, rf_out;
    logic [3:0]   rk_idx;
    logic [127:0] rks [16];

    int n_chk  = 0;
    int n_pass = 0;

    aes_round_ctrl #(.NR(NR)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .abort(abort), .rk_idx(rk_idx), .rk(rk),
        .rf_in(rf_in), .rf_final(rf_final), .rf_out(rf_out), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b  = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r, base, s;
        logic [7:0] e;
        r = 8'h01; base = x; e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, base);
            base = gmul(base, base);
        end
        if (x == 8'h00) r = 8'h00;
        s = r ^ ((r << 1) | (r >> 7)) ^ ((r << 2) | (r >> 6))
              ^ ((r << 3) | (r >> 5)) ^ ((r << 4) | (r >> 4)) ^ 8'h63;
        return s;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                                input logic fin);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[r+4*c] = b[r + 4*((c+r)%4)];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
                t[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ k;
    endfunction

    // combinational key store and round datapath
    assign rk = rks[rk_idx];
    always_comb rf_out = aes_round(rf_in, rk, rf_final);

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic key_expand();
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])};
                tmp = tmp ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 16; r++)
            rks[r] = (r <= NR) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    // one full block; hold = cycles out_ready stays low once out_valid is up
    task automatic do_block(input int hold);
        out_ready = (hold == 0);
        @(negedge clk);
        chk("idle_in_ready", 128'(in_ready), 128'd1);
        chk("idle_rk_idx", 128'(rk_idx), 128'd0);
        in_valid = 1'b1;
        data_in  = PT;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        data_in  = {$urandom, $urandom, $urandom, $urandom};
        for (int r = 1; r <= NR; r++) begin
            chk($sformatf("rk_idx_r%0d", r), 128'(rk_idx), 128'(r));
            chk($sformatf("rf_final_r%0d", r), 128'(rf_final), 128'(r == NR));
            chk($sformatf("out_valid_r%0d", r), 128'(out_valid), 128'd0);
            chk($sformatf("in_ready_r%0d", r), 128'(in_ready), 128'd0);
            @(posedge clk); @(negedge clk);
        end
        chk("out_valid_done", 128'(out_valid), 128'd1);
        chk("ciphertext", data_out, CT);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("hold_valid_%0d", h), 128'(out_valid), 128'd1);
            chk($sformatf("hold_data_%0d", h), data_out, CT);
            chk($sformatf("hold_in_ready_%0d", h), 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("pulse_end_valid", 128'(out_valid), 128'd0);
        chk("back_idle_ready", 128'(in_ready), 128'd1);
        chk("back_idle_busy", 128'(busy), 128'd0);
        out_ready = 1'b0;
    endtask

    // accept a block and run until the counter shows round n
    task automatic start_to_round(input int n);
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = PT;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        for (int i = 1; i < n; i++) begin
            @(posedge clk); @(negedge clk);
        end
        chk($sformatf("at_round_%0d", n), 128'(rk_idx), 128'(n));
    endtask

    initial begin
        int ov_cnt, ov_cyc0, ov_cyc1;
        logic [127:0] ov_dat0, ov_dat1;
        logic overlap;

        key_expand();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0; data_in = '0;

        // reset state
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_data_out", data_out, 128'd0);
        chk("rst_rk_idx", 128'(rk_idx), 128'd0);
        rst = 1'b1;
        #1 chk("rel_in_ready_low", 128'(in_ready), 128'd0);
        @(posedge clk); @(negedge clk);
        chk("rel_in_ready_high", 128'(in_ready), 128'd1);

        // FIPS-197 C.1, immediate consume, then with 20-cycle back-pressure
        do_block(0);
        do_block(20);

        // abort at round 5, then a clean block
        start_to_round(5);
        abort = 1'b1;
        @(posedge clk); @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_out_valid", 128'(out_valid), 128'd0);
        chk("abort_st", data_out, 128'd0);
        chk("abort_in_ready", 128'(in_ready), 128'd1);
        do_block(0);

        // abort in IDLE is ignored; abort with out_ready in DONE goes IDLE
        @(negedge clk);
        abort = 1'b1; in_valid = 1'b1; data_in = PT;
        @(posedge clk); @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        chk("idle_abort_busy", 128'(busy), 128'd1);
        repeat (NR) @(posedge clk);
        @(negedge clk);
        chk("done_valid", 128'(out_valid), 128'd1);
        chk("done_data", data_out, CT);
        abort = 1'b1; out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        abort = 1'b0; out_ready = 1'b0;
        chk("done_abort_valid", 128'(out_valid), 128'd0);
        chk("done_abort_st", data_out, 128'd0);
        chk("done_abort_ready", 128'(in_ready), 128'd1);

        // asynchronous reset in round 7
        start_to_round(7);
        #1 rst = 1'b0;
        #1;
        chk("arst_busy", 128'(busy), 128'd0);
        chk("arst_in_ready", 128'(in_ready), 128'd0);
        chk("arst_out_valid", 128'(out_valid), 128'd0);
        chk("arst_data_out", data_out, 128'd0);
        chk("arst_rk_idx", 128'(rk_idx), 128'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("arst_rel_ready_low", 128'(in_ready), 128'd0);
        @(posedge clk); @(negedge clk);
        chk("arst_rel_ready_high", 128'(in_ready), 128'd1);
        chk("arst_no_output", 128'(out_valid), 128'd0);

        // two blocks with in_valid held high; data wiggles while not ready
        ov_cnt = 0; ov_cyc0 = -1; ov_cyc1 = -1; ov_dat0 = '0; ov_dat1 = '0; overlap = 1'b0;
        in_valid = 1'b1; data_in = PT; out_ready = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); @(negedge clk);
            end
            if (in_ready && out_valid) overlap = 1'b1;
            if (out_valid) begin
                if (ov_cnt == 0) begin ov_cyc0 = cyc; ov_dat0 = data_out; end
                else if (ov_cnt == 1) begin ov_cyc1 = cyc; ov_dat1 = data_out; end
                ov_cnt++;
            end
            if (cyc == 3)  data_in = 128'hdeadbeef_01234567_89abcdef_feedface;
            if (cyc == 10) data_in = PT;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_count", 128'(ov_cnt), 128'd2);
        chk("b2b_first_cyc", 128'(ov_cyc0), 128'(NR + 1));
        chk("b2b_second_cyc", 128'(ov_cyc1), 128'(2 * NR + 3));
        chk("b2b_first_ct", ov_dat0, CT);
        chk("b2b_second_ct", ov_dat1, CT);
        chk("b2b_no_overlap", 128'(overlap), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
